// File: rtl/glyph_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_sched_pkg
//  Purpose  : Shared types and constants for the glyph fetch scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package glyph_sched_pkg;

  localparam int GLYPH_DIM = 16;   // glyphs are 16x16 pixels
  localparam int H_ACTIVE  = 640;  // visible pixel columns per line

  // Field order matches the cfg_writedata layout so a plain cast unpacks it.
  typedef struct packed {
    logic       enable;
    logic [3:0] code;
    logic [9:0] x;
    logic [9:0] y;
  } slot_cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/glyph_slot_regs.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_slot_regs
//  Purpose  : Pending/active slot configuration banks. Host writes land in
//             the pending bank; the scheduler only ever reads the active bank,
//             which is refreshed from pending at frame end while idle (or in
//             the first idle cycle after a frame end that arrived while busy).
//  Revision : 1.0  initial release
// ============================================================================
module glyph_slot_regs
  import glyph_sched_pkg::*;
#(
  parameter int NSLOTS = 8,
  parameter int IDX_W  = 3
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             cfg_write,
  input  logic [2:0]       cfg_addr,
  input  logic [24:0]      cfg_writedata,
  input  logic             frame_end,
  input  logic             idle,
  input  logic [IDX_W-1:0] rd_slot,
  output slot_cfg_t        rd_cfg
);

  slot_cfg_t r_pending [NSLOTS];
  slot_cfg_t r_active  [NSLOTS];
  logic      r_defer;
  logic      w_copy;

  // A frame end seen while busy is remembered and honoured once idle.
  assign w_copy = idle && (frame_end || r_defer);

  // Bank update: the copy reads the old pending value, so a host write in
  // the same cycle only becomes active at the following frame end.
  always_ff @(posedge clk50) begin
    if (reset) begin
      for (int i = 0; i < NSLOTS; i++) begin
        r_pending[i] <= '0;
        r_active[i]  <= '0;
      end
      r_defer <= 1'b0;
    end else begin
      if (w_copy) begin
        for (int i = 0; i < NSLOTS; i++) r_active[i] <= r_pending[i];
      end
      if (cfg_write && (int'(cfg_addr) < NSLOTS)) begin
        r_pending[cfg_addr[IDX_W-1:0]] <= slot_cfg_t'(cfg_writedata);
      end
      if (w_copy)         r_defer <= 1'b0;
      else if (frame_end) r_defer <= 1'b1;
    end
  end

  assign rd_cfg = r_active[rd_slot];

endmodule
`default_nettype wire

// File: rtl/glyph_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module   : glyph_fetch_sched
//  Purpose  : During horizontal blanking, walks all glyph slots in index
//             order, fetches the 16-pixel row of every slot that covers the
//             next scanline from the shared glyph ROM, and writes the opaque,
//             on-screen pixels into the line buffer.
//  Revision : 1.0  initial release
// ============================================================================
module glyph_fetch_sched
  import glyph_sched_pkg::*;
#(
  parameter int NSLOTS  = 8,
  parameter int ROM_LAT = 2
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        cfg_write,
  input  logic [2:0]  cfg_addr,
  input  logic [24:0] cfg_writedata,
  input  logic        line_start,
  input  logic [9:0]  next_line,
  input  logic        frame_end,
  output logic [11:0] rom_address,
  input  logic [23:0] rom_q,
  output logic        lb_clear,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [23:0] lb_wdata,
  output logic        busy,
  output logic        overrun
);

  localparam int IDX_W  = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int SLOT_W = $clog2(NSLOTS + 1);  // must also hold NSLOTS (end marker)
  localparam int DRN_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_t              r_state;
  logic [9:0]          r_line;
  logic [SLOT_W-1:0]   r_slot;
  logic [3:0]          r_col;
  logic [DRN_W-1:0]    r_drain;
  logic                r_overrun;
  logic [ROM_LAT-1:0]  r_vld;
  logic [9:0]          r_addr_pipe [ROM_LAT];

  slot_cfg_t           w_cfg;
  logic                w_idle;
  logic [10:0]         w_line11;
  logic [10:0]         w_y_lo;
  logic [10:0]         w_y_hi;
  logic                w_visible;
  logic [3:0]          w_row;
  logic [10:0]         w_pix11;
  logic                w_on_screen;

  glyph_slot_regs #(
    .NSLOTS (NSLOTS),
    .IDX_W  (IDX_W)
  ) u_slot_regs (
    .clk50         (clk50),
    .reset         (reset),
    .cfg_write     (cfg_write),
    .cfg_addr      (cfg_addr),
    .cfg_writedata (cfg_writedata),
    .frame_end     (frame_end),
    .idle          (w_idle),
    .rd_slot       (r_slot[IDX_W-1:0]),
    .rd_cfg        (w_cfg)
  );

  assign w_idle      = (r_state == IDLE);
  // 11-bit compares so a glyph near the bottom of the range never wraps.
  assign w_line11    = {1'b0, r_line};
  assign w_y_lo      = {1'b0, w_cfg.y};
  assign w_y_hi      = w_y_lo + 11'(GLYPH_DIM - 1);
  assign w_visible   = w_cfg.enable && (w_line11 >= w_y_lo) && (w_line11 <= w_y_hi);
  assign w_row       = r_line[3:0] - w_cfg.y[3:0];
  assign w_pix11     = {1'b0, w_cfg.x} + {7'b0, r_col};
  assign w_on_screen = (w_pix11 <= 11'(H_ACTIVE - 1));

  assign rom_address = (r_state == FETCH) ? {w_cfg.code, w_row, r_col} : 12'h000;
  assign busy        = !w_idle;
  assign overrun     = r_overrun;
  assign lb_clear    = w_idle && line_start && !reset;
  // Black is the transparent colour and is never written.
  assign lb_we       = r_vld[ROM_LAT-1] && (rom_q != 24'h000000);
  assign lb_addr     = r_addr_pipe[ROM_LAT-1];
  assign lb_wdata    = r_vld[ROM_LAT-1] ? rom_q : 24'h000000;

  // Slot walk: one SCAN cycle per slot plus a terminating SCAN at slot NSLOTS.
  always_ff @(posedge clk50) begin
    if (reset) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_slot  <= '0;
      r_col   <= '0;
      r_drain <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (line_start) begin
            r_line  <= next_line;
            r_slot  <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_slot == SLOT_W'(NSLOTS)) begin
            r_state <= IDLE;
          end else if (w_visible) begin
            r_col   <= '0;
            r_state <= FETCH;
          end else begin
            r_slot  <= r_slot + SLOT_W'(1);
          end
        end
        FETCH: begin
          if (r_col == 4'(GLYPH_DIM - 1)) begin
            r_drain <= '0;
            r_state <= DRAIN;
          end else begin
            r_col   <= r_col + 4'd1;
          end
        end
        DRAIN: begin
          if (r_drain == DRN_W'(ROM_LAT - 1)) begin
            r_slot  <= r_slot + SLOT_W'(1);
            r_state <= SCAN;
          end else begin
            r_drain <= r_drain + DRN_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write-enable/column pipeline aligned with the ROM read latency.
  always_ff @(posedge clk50) begin
    if (reset) begin
      r_vld <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_addr_pipe[i] <= '0;
    end else begin
      r_vld[0]       <= (r_state == FETCH) && w_on_screen;
      r_addr_pipe[0] <= w_pix11[9:0];
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vld[i]       <= r_vld[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
    end
  end

  // Sticky overrun: a new line requested before the previous one finished.
  always_ff @(posedge clk50) begin
    if (reset)                    r_overrun <= 1'b0;
    else if (line_start && !w_idle) r_overrun <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_glyph_fetch_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_glyph_fetch_sched
//  Purpose  : Self-checking bench for glyph_fetch_sched with a ROM model and
//             a slot-list reference model of the expected line-buffer writes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_glyph_fetch_sched;

  localparam int NSLOTS  = 8;
  localparam int ROM_LAT = 2;
  localparam int LIMIT   = 400;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        cfg_write;
  logic [2:0]  cfg_addr;
  logic [24:0] cfg_writedata;
  logic        line_start;
  logic [9:0]  next_line;
  logic        frame_end;
  logic [11:0] rom_address;
  logic [23:0] rom_q;
  logic        lb_clear;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [23:0] lb_wdata;
  logic        busy;
  logic        overrun;

  always #5 clk50 = ~clk50;

  glyph_fetch_sched #(.NSLOTS(NSLOTS), .ROM_LAT(ROM_LAT)) dut (
    .clk50         (clk50),
    .reset         (reset),
    .cfg_write     (cfg_write),
    .cfg_addr      (cfg_addr),
    .cfg_writedata (cfg_writedata),
    .line_start    (line_start),
    .next_line     (next_line),
    .frame_end     (frame_end),
    .rom_address   (rom_address),
    .rom_q         (rom_q),
    .lb_clear      (lb_clear),
    .lb_we         (lb_we),
    .lb_addr       (lb_addr),
    .lb_wdata      (lb_wdata),
    .busy          (busy),
    .overrun       (overrun)
  );

  // Glyph ROM contents: code 14 is transparent on odd columns, all else opaque.
  function automatic logic [23:0] rom_pix(input logic [11:0] a);
    logic [23:0] v;
    v = {a, ~a} ^ 24'h5A3C96;
    if (a[11:8] == 4'hE && a[0]) v = 24'h000000;
    return v;
  endfunction

  logic [23:0] rom_pipe [ROM_LAT];
  always @(posedge clk50) begin
    rom_pipe[0] <= rom_pix(rom_address);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  typedef struct { int en; int code; int x; int y; } mcfg_t;
  mcfg_t pend [NSLOTS];
  mcfg_t act  [NSLOTS];

  int          n_cmp = 0;
  int          n_mis = 0;
  int          last_bcnt;
  logic [33:0] exp_q [$];
  logic [33:0] wq    [$];
  int          wk    [$];
  logic [11:0] raq   [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic cfg_wr(input int s, input int en, input int code, input int x, input int y);
    cfg_write     = 1'b1;
    cfg_addr      = 3'(s);
    cfg_writedata = {1'(en), 4'(code), 10'(x), 10'(y)};
    pend[s]       = '{en, code, x, y};
    @(posedge clk50); #1;
    cfg_write     = 1'b0;
  endtask

  task automatic do_frame_end();
    frame_end = 1'b1;
    act       = pend;
    @(posedge clk50); #1;
    frame_end = 1'b0;
  endtask

  // Reference: slots in index order; covered slots cost 1+16+ROM_LAT cycles,
  // others 1, plus the closing scan. Writes are every opaque on-screen pixel.
  task automatic build_exp(input int nl, output int eb);
    exp_q.delete();
    eb = 1;
    for (int s = 0; s < NSLOTS; s++) begin
      if (act[s].en != 0 && nl >= act[s].y && nl <= act[s].y + 15) begin
        eb += 1 + 16 + ROM_LAT;
        for (int c = 0; c < 16; c++) begin
          int          col;
          logic [11:0] ra;
          logic [23:0] px;
          col = act[s].x + c;
          ra  = 12'(act[s].code * 256 + ((nl - act[s].y) % 16) * 16 + c);
          px  = rom_pix(ra);
          if (col <= 639 && px != 24'h0) exp_q.push_back({10'(col), px});
        end
      end else begin
        eb += 1;
      end
    end
  endtask

  task automatic run_line(input int nl, input int ovr_at, input int fe_at);
    int   eb;
    int   bcnt;
    logic done;
    build_exp(nl, eb);
    wq.delete(); wk.delete(); raq.delete();
    bcnt = 0;
    done = 1'b0;
    line_start = 1'b1;
    next_line  = 10'(nl);
    @(negedge clk50);
    check_eq("lb_clear", lb_clear, 1);
    @(posedge clk50); #1;
    for (int k = 0; k < LIMIT && !done; k++) begin
      line_start = (k == ovr_at);
      next_line  = (k == ovr_at) ? (10'(nl) ^ 10'h2AA) : 10'(nl);
      frame_end  = (k == fe_at);
      @(negedge clk50);
      raq.push_back(rom_address);
      if (lb_we) begin
        wq.push_back({lb_addr, lb_wdata});
        wk.push_back(k);
      end
      if (busy) bcnt++;
      else      done = 1'b1;
      @(posedge clk50); #1;
    end
    line_start = 1'b0;
    frame_end  = 1'b0;
    if (!done) check_eq("line_timeout", 0, 1);
    if (fe_at >= 0) act = pend;
    last_bcnt = bcnt;
    check_eq("busy_cycles", bcnt, eb);
    check_eq("n_writes", wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
      check_eq($sformatf("write%0d", i), wq[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_write = 1'b0; cfg_addr = '0; cfg_writedata = '0;
    line_start = 1'b0; next_line = '0; frame_end = 1'b0;
    for (int s = 0; s < NSLOTS; s++) pend[s] = '{0, 0, 0, 0};
    act = pend;
    repeat (3) @(posedge clk50);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk50);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_lb_we", lb_we, 0);
    check_eq("rst_lb_clear", lb_clear, 0);
    check_eq("rst_rom_address", rom_address, 0);
    check_eq("rst_lb_addr", lb_addr, 0);
    check_eq("rst_lb_wdata", lb_wdata, 0);
    @(posedge clk50); #1;

    // Pending write is invisible until frame end; frame end while busy defers
    cfg_wr(0, 1, 2, 200, 200);
    run_line(205, -1, 3);
    check_eq("pending_no_writes", wq.size(), 0);

    // Basic fetch with exact address sequence and latency
    run_line(205, -1, -1);
    check_eq("basic_nwr", wq.size(), 16);
    if (wk.size() > 0) check_eq("first_we_cycle", wk[0], 1 + ROM_LAT);
    if (raq.size() >= 18) begin
      check_eq("rom_addr_scan", raq[0], 0);
      for (int c = 0; c < 16; c++) check_eq($sformatf("rom_addr%0d", c), raq[1+c], 12'h250 + 12'(c));
      check_eq("rom_addr_drain", raq[17], 0);
    end else begin
      check_eq("rom_addr_len", raq.size(), 18);
    end

    // Line just below the glyph
    run_line(216, -1, -1);
    check_eq("busy_invisible", last_bcnt, NSLOTS + 1);

    // Right-edge clipping
    cfg_wr(0, 1, 2, 630, 200);
    do_frame_end();
    run_line(205, -1, -1);
    check_eq("edge_nwr", wq.size(), 10);
    if (wq.size() > 0) check_eq("edge_last_addr", wq[wq.size()-1][33:24], 639);

    // Overlap: slot 3 written after slot 1
    cfg_wr(0, 0, 0, 0, 0);
    cfg_wr(1, 1, 3, 100, 100);
    cfg_wr(3, 1, 7, 100, 100);
    do_frame_end();
    run_line(100, -1, -1);
    if (wq.size() == 32) begin
      check_eq("ovl_first_slot1", wq[0], {10'd100, rom_pix(12'h300)});
      check_eq("ovl_later_slot3", wq[16], {10'd100, rom_pix(12'h700)});
    end else begin
      check_eq("ovl_nwr", wq.size(), 32);
    end

    // Overrun: second line_start while busy is ignored
    check_eq("ovr_pre", overrun, 0);
    run_line(100, 5, -1);
    check_eq("ovr_post", overrun, 1);

    // Host write in the same cycle as the bank copy
    cfg_wr(1, 1, 5, 300, 100);
    cfg_write = 1'b1; cfg_addr = 3'd1; cfg_writedata = {1'b1, 4'd9, 10'd400, 10'd100};
    frame_end = 1'b1;
    act = pend;
    pend[1] = '{1, 9, 400, 100};
    @(posedge clk50); #1;
    cfg_write = 1'b0; frame_end = 1'b0;
    run_line(100, -1, -1);
    do_frame_end();
    run_line(100, -1, -1);

    // Randomized configurations and lines
    for (int it = 0; it < 30; it++) begin
      int nw, mode, s, nl;
      nw = $urandom_range(1, 4);
      for (int j = 0; j < nw; j++)
        cfg_wr($urandom_range(0, 7), ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 15),
               ($urandom_range(0, 2) == 0) ? $urandom_range(600, 659) : $urandom_range(0, 659),
               $urandom_range(0, 1023));
      mode = $urandom_range(0, 2);
      if (mode == 0) do_frame_end();
      s  = $urandom_range(0, 7);
      nl = ($urandom_range(0, 4) != 0) ? (act[s].y + $urandom_range(0, 18)) % 1024
                                       : $urandom_range(0, 1023);
      run_line(nl, -1, (mode == 1) ? 2 : -1);
    end

    // Reset in the middle of a fetch
    for (int s = 0; s < NSLOTS; s++) cfg_wr(s, 0, 0, 0, 0);
    cfg_wr(0, 1, 2, 200, 200);
    do_frame_end();
    check_eq("ovr_sticky", overrun, 1);
    line_start = 1'b1; next_line = 10'd205;
    @(posedge clk50); #1;
    line_start = 1'b0;
    repeat (4) @(posedge clk50);
    #1;
    @(negedge clk50);
    check_eq("we_before_rst", lb_we, 1);
    @(posedge clk50); #1;
    reset = 1'b1;
    @(posedge clk50); #1;
    reset = 1'b0;
    @(negedge clk50);
    check_eq("midrst_lb_we", lb_we, 0);
    check_eq("midrst_overrun", overrun, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_rom_address", rom_address, 0);
    @(posedge clk50); #1;
    for (int s = 0; s < NSLOTS; s++) pend[s] = '{0, 0, 0, 0};
    act = pend;
    run_line(205, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
